// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array result register file.
package sa_pkg;

   localparam int N     = 8;
   localparam int ACC_W = 20;
   localparam int IDX_W = 3;

   // Number of rows in a full buffer, sized to the row counter.
   localparam logic [IDX_W:0] ROWS_FULL = (IDX_W + 1)'(N);

   typedef logic [ACC_W-1:0] acc_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } rf_state_e;

endpackage : sa_pkg

// File: rtl/result_rf_lane_delay.sv
// Fixed-depth delay line used to remove the diagonal skew on one result lane.
// A depth of zero is a plain wire.
module lane_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      assign dout = din;
   end else begin : g_pipe
      logic [W-1:0] pipe [DEPTH];

      // Shift every cycle; reset clears all stages so no stale data emerges.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
         end else begin
            // NOTE: non-blocking assignments make each stage read the previous
            // stage's old value, so this is a true shift register.
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
         end
      end

      assign dout = pipe[DEPTH-1];
   end

endmodule : lane_delay

// File: rtl/result_rf.sv
// Result register file: deskews the array's output lanes, assembles N result
// rows into a buffer, and serves indexed row reads to the host once full.
module result_rf
   import sa_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  acc_t [N-1:0]     in_data,
   input  logic             release_req,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output acc_t [N-1:0]     rd_data,
   output logic             rd_valid,
   output logic             ready,
   output logic [IDX_W:0]   row_cnt,
   output logic             overflow
);

   acc_t [N-1:0]     aligned;
   logic             align_valid;

   rf_state_e        state, state_nxt;
   logic [IDX_W:0]   cnt_nxt;
   logic             ovf_nxt;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic             rd_fire;

   acc_t [N-1:0]     buffer [N];

   // Lane k entered the array k cycles after lane 0; delay it by N-1-k so all
   // lanes of a row line up with lane N-1.
   for (genvar k = 0; k < N; k++) begin : g_lane
      lane_delay #(
         .DEPTH (N - 1 - k),
         .W     (ACC_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (in_data[k]),
         .dout  (aligned[k])
      );
   end

   lane_delay #(
      .DEPTH (N - 1),
      .W     (1)
   ) u_valid (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (in_valid),
      .dout  (align_valid)
   );

   // Next-state logic: release is applied first, then an aligned row is
   // written into the (possibly just emptied) buffer unless it is full.
   always_comb begin
      rf_state_e      eff_state;
      logic [IDX_W:0] eff_cnt;
      // NOTE: every output gets a default before any branch so no path leaves
      // a signal unassigned and no latch is inferred.
      eff_state = state;
      eff_cnt   = row_cnt;
      state_nxt = state;
      cnt_nxt   = row_cnt;
      ovf_nxt   = overflow;
      wr_en     = 1'b0;
      wr_idx    = '0;

      if (release_req) begin
         eff_state = EMPTY;
         eff_cnt   = '0;
         ovf_nxt   = 1'b0;
      end

      state_nxt = eff_state;
      cnt_nxt   = eff_cnt;

      if (align_valid) begin
         if (eff_state == FULL) begin
            ovf_nxt = 1'b1;
         end else begin
            wr_en     = 1'b1;
            wr_idx    = eff_cnt[IDX_W-1:0];
            cnt_nxt   = eff_cnt + {{IDX_W{1'b0}}, 1'b1};
            state_nxt = (cnt_nxt == ROWS_FULL) ? FULL : FILL;
         end
      end
   end

   // State, row count and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         row_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         row_cnt  <= cnt_nxt;
         overflow <= ovf_nxt;
      end
   end

   // Row storage write port.
   // NOTE: the buffer is deliberately not reset; it is only read in FULL, by
   // which time every row has been written, so a reset would be pure cost.
   always_ff @(posedge clk) begin
      if (wr_en) buffer[wr_idx] <= aligned;
   end

   // Reads are judged against the pre-release state, so a read in the same
   // cycle as release still returns the old contents.
   assign rd_fire = rd_en && (state == FULL);

   // Registered read port; data holds when no read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) rd_data <= buffer[rd_idx];
      end
   end

   assign ready = (state == FULL);

endmodule : result_rf
